adc_sample_buffer: RTL and testbench

Downstream stage of `digital_filter`. Captures each 12-bit decimated sample when the filter raises `new_data`, queues it in a small FIFO, and returns queued samples to an external SPI-style master through a 16-bit serial frame. Lets the off-chip reader fall behind the filter by up to `DEPTH` conversions without losing data, and flags overflow when it falls further behind.

---
 rtl/adc_sample_buffer_if.sv | 24 ++
 rtl/adc_sample_buffer.sv | 101 ++++++++++
 tb/tb_adc_sample_buffer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/adc_sample_buffer_if.sv
// Bus bundle between the off-chip reader side and adc_sample_buffer.
//   data_in/new_data     : filter sample and valid level (clk domain)
//   sclk/cs_n            : asynchronous serial clock and frame select
//   serial_data_out      : frame bit, MSB first
//   data_ready/overflow  : FIFO non-empty, sticky drop flag
//   level                : FIFO occupancy 0..DEPTH
interface adc_sample_buffer_if #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 8
);
  logic [DATA_W-1:0]        data_in;
  logic                     new_data;
  logic                     sclk;
  logic                     cs_n;
  logic                     serial_data_out;
  logic                     data_ready;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   level;

  modport master (output data_in, new_data, sclk, cs_n,
                  input  serial_data_out, data_ready, overflow, level);
  modport slave  (input  data_in, new_data, sclk, cs_n,
                  output serial_data_out, data_ready, overflow, level);
endinterface

// File: rtl/adc_sample_buffer.sv
// Sample FIFO behind digital_filter, drained by an external SPI-style master.
// Each new_data rising edge pushes data_in; each cs_n frame pops at most one
// sample and shifts out {valid, overflow, 2'b00, sample} MSB first on sclk
// falling edges.
//   clk, rst_n : system clock, synchronous active-low reset
//   bus        : adc_sample_buffer_if.slave (see interface header)
module adc_sample_buffer #(
  parameter int DATA_W      = 12,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  adc_sample_buffer_if.slave   bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t                 state, state_n;
  logic                   nd_q, push_r;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic                   sclk_d, cs_d;
  logic [AW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level_q;
  logic                   ovf_q;
  logic [15:0]            sr;
  logic [DATA_W-1:0]      mem [DEPTH];

  logic sclk_s, cs_s, sclk_fall, cs_fall, cs_rise;
  logic pop, accept, drop;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_fall = sclk_d & ~sclk_s;
  assign cs_fall   = cs_d & ~cs_s;
  assign cs_rise   = ~cs_d & cs_s;

  // Pop only in LOAD with data queued; a push into a full FIFO still fits
  // when the head leaves on the same cycle.
  assign pop    = (state == LOAD) && (level_q != '0);
  assign accept = push_r && ((level_q != FULL) || pop);
  assign drop   = push_r && !accept;

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (cs_fall) state_n = LOAD;
      LOAD:    state_n = SHIFT;
      SHIFT:   state_n = SHIFT;
      default: state_n = IDLE;
    endcase
    if (cs_rise) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      nd_q      <= 1'b0;
      push_r    <= 1'b0;
      sclk_sync <= '0;
      cs_sync   <= '1;     // idle-high so a low cs_n at release opens a frame
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      sr        <= '0;
    end else begin
      state     <= state_n;
      nd_q      <= bus.new_data;
      push_r    <= bus.new_data & ~nd_q;
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      level_q <= level_q + {{(LW-1){1'b0}}, accept} - {{(LW-1){1'b0}}, pop};
      // A drop in the LOAD cycle wins over the clear.
      if (drop)               ovf_q <= 1'b1;
      else if (state == LOAD) ovf_q <= 1'b0;
      if (state == LOAD)
        sr <= pop ? {1'b1, ovf_q, 14'(mem[rd_ptr])} : {1'b0, ovf_q, 14'b0};
      else if (state == SHIFT && sclk_fall && !cs_rise)
        sr <= {sr[14:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= bus.data_in;
  end

  assign bus.serial_data_out = (state == SHIFT) & sr[15];
  assign bus.data_ready      = (level_q != '0);
  assign bus.overflow        = ovf_q;
  assign bus.level           = level_q;
endmodule

// File: tb/tb_adc_sample_buffer.sv
module tb_adc_sample_buffer;
  localparam int DATA_W = 12;
  localparam int DEPTH  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  adc_sample_buffer_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();
  adc_sample_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic push(input logic [11:0] v);
    bus.data_in  = v;
    bus.new_data = 1'b1;
    repeat (3) @(negedge clk);
    bus.new_data = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic shift_bits(input int n, output logic [15:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      bits[15-i] = bus.serial_data_out;
      bus.sclk = 1'b1;
      repeat (5) @(negedge clk);
      bus.sclk = 1'b0;
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic read_frame(output logic [15:0] v);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(16, v);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.data_in  = 12'($urandom);
      bus.new_data = 1'($urandom);
      bus.sclk     = 1'($urandom);
      bus.cs_n     = 1'($urandom);
      @(negedge clk);
      n_chk++;
      if ({bus.serial_data_out, bus.data_ready, bus.overflow, bus.level} !== 7'd0)
        $display("FAIL reset_outputs got %b want 0",
                 {bus.serial_data_out, bus.data_ready, bus.overflow, bus.level});
      else n_pass++;
    end
    bus.new_data = 1'b0; bus.sclk = 1'b0; bus.cs_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (bus.level !== 4'd0) $display("FAIL reset_level got %0d want 0", bus.level);
    else n_pass++;
  endtask

  task automatic test_single;
    logic [15:0] f;
    push(12'hA5C);
    n_chk++;
    if (bus.level !== 4'd1 || bus.data_ready !== 1'b1)
      $display("FAIL single_push level=%0d rdy=%b want 1/1", bus.level, bus.data_ready);
    else n_pass++;
    read_frame(f);
    n_chk++;
    if (f !== 16'h8A5C) $display("FAIL single_frame got %h want 8a5c", f);
    else n_pass++;
    n_chk++;
    if (bus.level !== 4'd0 || bus.data_ready !== 1'b0)
      $display("FAIL single_after level=%0d rdy=%b want 0/0", bus.level, bus.data_ready);
    else n_pass++;
  endtask

  task automatic test_overflow;
    logic [15:0] f;
    logic [15:0] exp;
    for (int i = 1; i <= 9; i++) push(12'(i));
    n_chk++;
    if (bus.level !== 4'd8 || bus.overflow !== 1'b1)
      $display("FAIL fill level=%0d ovf=%b want 8/1", bus.level, bus.overflow);
    else n_pass++;
    read_frame(f);
    n_chk++;
    if (f !== 16'hC001) $display("FAIL ovf_frame got %h want c001", f);
    else n_pass++;
    n_chk++;
    if (bus.overflow !== 1'b0) $display("FAIL ovf_clear got %b want 0", bus.overflow);
    else n_pass++;
    for (int i = 2; i <= 8; i++) begin
      read_frame(f);
      exp = 16'h8000 | 16'(i);
      n_chk++;
      if (f !== exp) $display("FAIL drain_frame%0d got %h want %h", i, f, exp);
      else n_pass++;
    end
    read_frame(f);
    n_chk++;
    if (f !== 16'h0000 || bus.level !== 4'd0)
      $display("FAIL empty_frame got %h level=%0d want 0000/0", f, bus.level);
    else n_pass++;
  endtask

  task automatic test_empty_push;
    logic [15:0] f;
    // Time the push edge so its registered request lands in the LOAD cycle.
    bus.cs_n = 1'b0;
    repeat (2) @(negedge clk);
    bus.data_in  = 12'h3C7;
    bus.new_data = 1'b1;
    repeat (4) @(negedge clk);
    bus.new_data = 1'b0;
    shift_bits(16, f);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (f !== 16'h0000) $display("FAIL loadpush_frame got %h want 0000", f);
    else n_pass++;
    n_chk++;
    if (bus.level !== 4'd1) $display("FAIL loadpush_level got %0d want 1", bus.level);
    else n_pass++;
    read_frame(f);
    n_chk++;
    if (f !== 16'h83C7) $display("FAIL loadpush_next got %h want 83c7", f);
    else n_pass++;
  endtask

  task automatic test_abort;
    logic [15:0] f;
    push(12'h111);
    push(12'h222);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(5, f);
    n_chk++;
    if (f[15:11] !== 5'b10000) $display("FAIL abort_bits got %b want 10000", f[15:11]);
    else n_pass++;
    bus.cs_n = 1'b1;
    repeat (5) @(negedge clk);
    n_chk++;
    if (bus.serial_data_out !== 1'b0 || bus.level !== 4'd1)
      $display("FAIL abort_idle sdo=%b level=%0d want 0/1", bus.serial_data_out, bus.level);
    else n_pass++;
    read_frame(f);
    n_chk++;
    if (f !== 16'h8222 || bus.overflow !== 1'b0)
      $display("FAIL abort_next got %h ovf=%b want 8222/0", f, bus.overflow);
    else n_pass++;
  endtask

  task automatic test_midframe_reset;
    logic [15:0] f;
    push(12'h0AA); push(12'h0BB); push(12'h0CC);
    bus.cs_n = 1'b0;
    repeat (6) @(negedge clk);
    shift_bits(3, f);
    bus.sclk = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.serial_data_out, bus.data_ready, bus.overflow, bus.level} !== 7'd0)
      $display("FAIL midreset_outputs got %b want 0",
               {bus.serial_data_out, bus.data_ready, bus.overflow, bus.level});
    else n_pass++;
    bus.sclk = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    shift_bits(16, f);
    bus.cs_n = 1'b1;
    repeat (6) @(negedge clk);
    n_chk++;
    if (f !== 16'h0000 || bus.level !== 4'd0)
      $display("FAIL midreset_frame got %h level=%0d want 0000/0", f, bus.level);
    else n_pass++;
  endtask

  initial begin
    bus.data_in = '0; bus.new_data = 1'b0; bus.sclk = 1'b0; bus.cs_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_single();
    test_overflow();
    test_empty_push();
    test_abort();
    test_midframe_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
